// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: carry chain split into STAGE_W-bit segments,
// one segment per stage, global-stall valid/ready, optional unsigned saturation.
module adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_sat,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);
    localparam int STAGES = WIDTH / STAGE_W;
    localparam int L      = STAGES - 1;

    // Index 0 is the operand capture register; index j holds the state after
    // j segments have been resolved. Operands shift down so the next segment
    // is always in the low bits; the partial sum shifts in from the top.
    logic             w_adv;
    logic [L:0]       r_vld;
    logic [L:0]       r_c;
    logic [L:0]       r_sub;
    logic [L:0]       r_sat;
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];

    logic [STAGE_W:0] w_last;
    logic [WIDTH-1:0] w_sum;
    logic             w_cmsb;
    logic             w_v;
    logic [WIDTH-1:0] w_res;

    assign w_adv   = !o_valid || i_ready;
    assign o_ready = w_adv && !i_rst;

    // Capture operands, invert B and inject carry-in for subtraction
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld[0] <= 1'b0;
            r_c[0]   <= 1'b0;
            r_sub[0] <= 1'b0;
            r_sat[0] <= 1'b0;
            r_a[0]   <= '0;
            r_b[0]   <= '0;
            r_s[0]   <= '0;
        end else if (w_adv) begin
            r_vld[0] <= i_valid;
            r_c[0]   <= i_sub;
            r_sub[0] <= i_sub;
            r_sat[0] <= i_sat;
            r_a[0]   <= i_a;
            r_b[0]   <= i_sub ? ~i_b : i_b;
            r_s[0]   <= '0;
        end
    end

    for (genvar j = 1; j < STAGES; j++) begin : g_stage
        logic [STAGE_W:0] w_seg;

        assign w_seg = {1'b0, r_a[j-1][STAGE_W-1:0]}
                     + {1'b0, r_b[j-1][STAGE_W-1:0]}
                     + {{STAGE_W{1'b0}}, r_c[j-1]};

        // Resolve one segment and skew the remaining operand bits forward
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_vld[j] <= 1'b0;
                r_c[j]   <= 1'b0;
                r_sub[j] <= 1'b0;
                r_sat[j] <= 1'b0;
                r_a[j]   <= '0;
                r_b[j]   <= '0;
                r_s[j]   <= '0;
            end else if (w_adv) begin
                r_vld[j] <= r_vld[j-1];
                r_c[j]   <= w_seg[STAGE_W];
                r_sub[j] <= r_sub[j-1];
                r_sat[j] <= r_sat[j-1];
                r_a[j]   <= r_a[j-1] >> STAGE_W;
                r_b[j]   <= r_b[j-1] >> STAGE_W;
                r_s[j]   <= {w_seg[STAGE_W-1:0], r_s[j-1][WIDTH-1:STAGE_W]};
            end
        end
    end

    assign w_last = {1'b0, r_a[L][STAGE_W-1:0]}
                  + {1'b0, r_b[L][STAGE_W-1:0]}
                  + {{STAGE_W{1'b0}}, r_c[L]};

    if (STAGES > 1) begin : g_multi
        assign w_sum = {w_last[STAGE_W-1:0], r_s[L][WIDTH-1:STAGE_W]};
    end else begin : g_single
        assign w_sum = w_last[STAGE_W-1:0];
    end

    // Carry into the MSB recovered from the MSB's own sum bit
    assign w_cmsb = r_a[L][STAGE_W-1] ^ r_b[L][STAGE_W-1] ^ w_last[STAGE_W-1];
    assign w_v    = w_cmsb ^ w_last[STAGE_W];

    // Saturation select: overflow clamps high, borrow clamps low
    always_comb begin
        w_res = w_sum;
        if (r_sat[L] && !r_sub[L] && w_last[STAGE_W]) begin
            w_res = '1;
        end else if (r_sat[L] && r_sub[L] && !w_last[STAGE_W]) begin
            w_res = '0;
        end
    end

    // Final segment plus registered result, held while the sink stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (w_adv) begin
            o_valid <= r_vld[L];
            if (r_vld[L]) begin
                o_sum      <= w_res;
                o_carry    <= w_last[STAGE_W];
                o_overflow <= w_v;
            end
        end
    end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined two-operand adder/subtractor with valid/ready flow control, optional unsigned saturation and signed-overflow flag. It is the multi-bit, registered successor to the team's single-bit half adder. It splits a WIDTH-bit carry chain into STAGE_W-bit segments, one segment per pipeline stage, so wide datapaths close timing. It sits between a valid/ready operand source and a valid/ready result sink.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of STAGE_W
- STAGE_W, 8, bits resolved per pipeline stage; STAGES = WIDTH/STAGE_W (latency in cycles)

- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  operand beat valid
- o_ready  output  1  block can accept an operand beat this cycle
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_sub  input  1  0: A+B, 1: A-B
- i_sat  input  1  0: wrap, 1: unsigned saturate
- o_valid  output  1  result beat valid
- i_ready  input  1  sink accepts result this cycle
- o_sum  output  WIDTH  result
- o_carry  output  1  carry-out of MSB (in subtract mode, 1 = no borrow)
- o_overflow  output  1  two's-complement signed overflow of the unsaturated result

## Operation
- Accept when i_valid && o_ready. Capture i_a, B' = i_sub ? ~i_b : i_b, carry-in = i_sub, i_sub, i_sat.
- Stage s (0..STAGES-1) adds bits [s*STAGE_W +: STAGE_W] of A and B' plus the carry from stage s-1 (carry-in for s=0). It registers the partial sum, the segment carry, and skews still-unused operand segments forward.
- Last stage forms raw sum S, carry C (carry out of bit WIDTH-1) and V = carry into MSB XOR C.
- Saturation (i_sat captured = 1):
  - add with C=1 -> o_sum = all ones
  - sub with C=0 (borrow) -> o_sum = 0
  - otherwise o_sum = S
- o_carry = C and o_overflow = V regardless of i_sat.
- Each beat carries its own i_sub/i_sat; modes may change every beat.
- Flow control uses a global stall: advance = !o_valid || i_ready; o_ready = advance. When advance = 0, every stage, including its valid bit, holds.
- Bubbles are not compressed; a stage's valid bit propagates with its data.
- Order preserved; no beat dropped or duplicated.

## Timing
- Reset (async assert, sync to i_clk edge on release): all stage valid bits 0, o_valid 0, o_sum 0, o_carry 0, o_overflow 0.
  - o_ready is 1 from the first cycle after reset deasserts; it is 0 while i_rst is high.
- Latency: a beat accepted at edge k appears with o_valid = 1 after edge k+STAGES (4 for defaults).
- Throughput is one beat/cycle while i_ready = 1.
- o_sum, o_carry and o_overflow are registered and stable while o_valid && !i_ready.
- Simultaneous cases:
  - Full pipe with i_ready rising: the output beat retires and a new input is accepted in the same cycle.
  - i_valid with o_ready = 0: the beat is not taken, and the source must hold it.
- Reset mid-operation: all in-flight beats are discarded immediately; o_valid drops asynchronously; no stale beat is emitted after release.
- WIDTH == STAGE_W: single stage, latency 1.

## Test plan
- Carry across a segment, WIDTH=32, STAGE_W=8: A=0x000000FF, B=0x00000001, add -> o_sum=0x00000100, o_carry=0, o_overflow=0, o_valid exactly 4 cycles after accept.
- Unsigned wrap vs saturate: A=0xFFFFFFFF, B=1, i_sat=0 -> 0x00000000, carry 1. Same operands with i_sat=1 -> 0xFFFFFFFF, carry 1.
- Subtract: A=5, B=7, i_sub=1. With i_sat=0 -> 0xFFFFFFFE, carry 0. With i_sat=1 -> 0x00000000, carry 0. A=7, B=5 -> 0x00000002, carry 1.
- Signed overflow:
  - A=0x7FFFFFFF + B=1 -> 0x80000000, o_overflow=1
  - A=0x80000000 − B=1 -> 0x7FFFFFFF, o_overflow=1
- Backpressure: 16 random back-to-back beats with mixed i_sub/i_sat while i_ready toggles pseudo-randomly. Results must match the reference model in order, with no loss or duplication. Outputs must hold while stalled, and o_ready must equal !o_valid || i_ready.
- Reset mid-flight: accept 3 beats, assert i_rst between edges -> o_valid 0 at once, all outputs 0. After release, no result appears until a new beat is accepted, which then returns after 4 cycles.
